lcd_nibble_tx: RTL and testbench

- Downstream transfer stage of the LCD init/text sequencer; turns one 5-bit command (RS + 4-bit nibble) into a timed 4-bit HD44780 bus write.
- Sequence per command: drive LCD_D, set-up, E pulse, hold, then a caller-specified post-command delay.
- Signals completion with a one-cycle commandDone pulse so the sequencer can advance to its next step.
- Sits between the sequencer and the LCD pins.

---
 rtl/lcd_pkg.sv | 35 +++
 rtl/lcd_nibble_tx_counter.sv | 29 ++
 rtl/lcd_nibble_tx.sv | 142 ++++++++++++++
 tb/tb_lcd_nibble_tx.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD init/text sequencer and the nibble transfer stage.
// Timing constants are expressed in clk cycles at the nominal system frequency.
package lcd_pkg;

  localparam int FREQ = 50_000_000;

  localparam int RS_BIT = 4;

  localparam int T1US   = FREQ / 1_000_000;
  localparam int T10US  = 10 * T1US;
  localparam int T53US  = 53 * T1US;
  localparam int T100US = 100 * T1US;
  localparam int T3MS   = 3000 * T1US;
  localparam int T4_1MS = 4100 * T1US;

  localparam int DEF_T_SETUP = 3;
  localparam int DEF_T_EPW   = 12;
  localparam int DEF_T_HOLD  = 2;
  localparam int DEF_DELAY_W = 21;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_EHIGH = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DELAY = 3'd4,
    ST_DONE  = 3'd5,
    ST_REARM = 3'd6
  } lcd_state_e;

  function automatic int cycles_for_us(input int us);
    return us * T1US;
  endfunction

endpackage

// File: rtl/lcd_nibble_tx_counter.sv
// Loadable down-counter shared by every timed phase of the nibble transfer.
// It saturates at zero so an idle enable can never wrap it.
module lcd_delay_counter
  import lcd_pkg::*;
#(
  parameter int WIDTH = DEF_DELAY_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (en && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/lcd_nibble_tx.sv
// Turns one {RS, nibble} command into a timed HD44780 4-bit bus write followed
// by a caller-chosen wait, then pulses commandDone for one cycle.
//
// state | meaning
// IDLE  | waiting for sendCommand; latches command and delay on acceptance
// SETUP | LCD_D/RS stable, E low, T_SETUP cycles
// EHIGH | E high, T_EPW cycles
// HOLD  | E low, LCD_D held, T_HOLD cycles
// DELAY | post-command wait of the latched delay
// DONE  | commandDone high for this single cycle
// REARM | waits for sendCommand to drop so a held request cannot retrigger
module lcd_nibble_tx
  import lcd_pkg::*;
#(
  parameter int T_SETUP = DEF_T_SETUP,
  parameter int T_EPW   = DEF_T_EPW,
  parameter int T_HOLD  = DEF_T_HOLD,
  parameter int DELAY_W = DEF_DELAY_W
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               sendCommand,
  input  logic [4:0]         command,
  input  logic [DELAY_W-1:0] commandDelay,
  output logic               commandDone,
  output logic               busy,
  output logic [4:0]         LCD_D,
  output logic               LCD_E
);

  lcd_state_e         state, next_state;
  logic [DELAY_W-1:0] delay_q;
  logic               accept;
  logic               cnt_load;
  logic               cnt_en;
  logic [DELAY_W-1:0] cnt_value;
  logic [DELAY_W-1:0] cnt_count;
  logic               cnt_zero;

  lcd_delay_counter #(
    .WIDTH(DELAY_W)
  ) u_cnt (
    .clk   (CLK),
    .rst_n (RST_N),
    .load  (cnt_load),
    .en    (cnt_en),
    .value (cnt_value),
    .count (cnt_count),
    .zero  (cnt_zero)
  );

  // Each phase loads N-1 so that the phase lasts exactly N cycles including the
  // cycle on which the zero flag triggers the transition.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;
    cnt_value  = '0;
    case (state)
      ST_IDLE: begin
        if (sendCommand) begin
          accept     = 1'b1;
          cnt_load   = 1'b1;
          cnt_value  = DELAY_W'(T_SETUP - 1);
          next_state = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          cnt_load   = 1'b1;
          cnt_value  = DELAY_W'(T_EPW - 1);
          next_state = ST_EHIGH;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_EHIGH: begin
        if (cnt_zero) begin
          cnt_load   = 1'b1;
          cnt_value  = DELAY_W'(T_HOLD - 1);
          next_state = ST_HOLD;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_zero) begin
          if (delay_q == '0) begin
            next_state = ST_DONE;
          end else begin
            cnt_load   = 1'b1;
            cnt_value  = delay_q - DELAY_W'(1);
            next_state = ST_DELAY;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_DELAY: begin
        if (cnt_zero) begin
          next_state = ST_DONE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_DONE: begin
        next_state = ST_REARM;
      end
      ST_REARM: begin
        if (!sendCommand) begin
          next_state = ST_IDLE;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered from next_state so they line up with the state they describe.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= ST_IDLE;
      delay_q     <= '0;
      LCD_D       <= '0;
      LCD_E       <= 1'b0;
      commandDone <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= next_state;
      LCD_E       <= (next_state == ST_EHIGH);
      commandDone <= (next_state == ST_DONE);
      busy        <= (next_state != ST_IDLE);
      if (accept) begin
        LCD_D   <= command;
        delay_q <= commandDelay;
      end
    end
  end

endmodule

// File: tb/tb_lcd_nibble_tx.sv
// Scoreboard bench for lcd_nibble_tx: stimulus queues expected done cycle and
// bus value, a negedge monitor pops and compares on every commandDone pulse.
module tb_lcd_nibble_tx;

  localparam int DW  = 12;
  localparam int LAT = 17;   // 3 setup + 12 E-high + 2 hold cycles after the accept edge
  localparam int EPW = 12;

  typedef struct {
    int         cyc;
    logic [4:0] d;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          send_command;
  logic [4:0]    command;
  logic [DW-1:0] command_delay;
  logic          command_done;
  logic          busy;
  logic [4:0]    lcd_d;
  logic          lcd_e;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  logic prev_done = 1'b0;
  int   e_len = 0;

  lcd_nibble_tx #(
    .DELAY_W(DW)
  ) dut (
    .CLK          (clk),
    .RST_N        (rst_n),
    .sendCommand  (send_command),
    .command      (command),
    .commandDelay (command_delay),
    .commandDone  (command_done),
    .busy         (busy),
    .LCD_D        (lcd_d),
    .LCD_E        (lcd_e)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (command_done) begin
        chk("done_expected", int'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("done_lcd_d", int'(lcd_d), int'(e.d));
        end
      end
      if (prev_done) chk("done_width", int'(command_done), 0);
      if (lcd_e) begin
        e_len <= e_len + 1;
      end else if (e_len != 0) begin
        chk("e_width", e_len, EPW);
        e_len <= 0;
      end
    end
    prev_done <= command_done;
  end

  task automatic send(input logic [4:0] c, input int d, output int a);
    exp_t e;
    for (int n = 0; n < 200 && busy; n++) @(negedge clk);
    if (busy) chk("send_idle_wait", int'(busy), 0);
    command       = c;
    command_delay = DW'(d);
    send_command  = 1'b1;
    a     = cyc + 1;
    e.cyc = a + LAT + d;
    e.d   = c;
    sb.push_back(e);
  endtask

  task automatic wait_done(input int budget, output int x);
    for (int n = 0; n < budget && !command_done; n++) @(negedge clk);
    if (!command_done) chk("done_timeout", int'(command_done), 1);
    x = cyc;
  endtask

  initial begin
    int a, x, rise, fall, eh;
    rst_n         = 1'b0;
    send_command  = 1'b0;
    command       = '0;
    command_delay = '0;
    repeat (3) @(negedge clk);
    chk("rst_e", int'(lcd_e), 0);
    chk("rst_d", int'(lcd_d), 0);
    chk("rst_done", int'(command_done), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single command, D=0, request held
    send(5'b00011, 0, a);
    rise = -1;
    fall = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (cyc == a) chk("t1_lcd_d", int'(lcd_d), 5'b00011);
      if (lcd_e && rise < 0) rise = cyc;
      if (!lcd_e && rise >= 0 && fall < 0) fall = cyc;
    end
    chk("t1_e_rise", rise, a + 3);
    chk("t1_e_fall", fall, a + 15);
    chk("t1_busy_rearm", int'(busy), 1);
    send_command = 1'b0;
    @(negedge clk);
    chk("t1_busy_idle", int'(busy), 0);

    // data write with a 53 us delay
    send(5'b11000, 2650, a);
    wait_done(3000, x);
    chk("t2_rs", int'(lcd_d[4]), 1);
    send_command = 1'b0;
    repeat (5) @(negedge clk);
    chk("t2_lcd_d_hold", int'(lcd_d), 5'b11000);

    // back-to-back handshake over 16 commands
    send(5'b00010, 0, a);
    wait_done(100, x);
    for (int i = 1; i < 16; i++) begin
      send_command = 1'b0;
      send(5'((i * 7 + 3) & 31), i % 4, a);
      chk("b2b_accept", a, x + 3);
      wait_done(100, x);
    end
    send_command = 1'b0;

    // request held long after done must not retrigger
    send(5'b00110, 5, a);
    wait_done(100, x);
    eh = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (lcd_e) eh++;
    end
    chk("held_e_count", eh, 0);
    chk("held_busy", int'(busy), 1);
    send_command = 1'b0;
    send(5'b01001, 1, a);
    chk("held_rearm_accept", a, x + 1002);
    wait_done(100, x);
    send_command = 1'b0;

    // inputs change and request drops while E is high
    send(5'b10110, 4, a);
    for (int n = 0; n < 20 && !lcd_e; n++) @(negedge clk);
    chk("mid_e_seen", int'(lcd_e), 1);
    command       = 5'b01001;
    command_delay = DW'(9);
    send_command  = 1'b0;
    wait_done(100, x);

    // reset during DELAY aborts without a done pulse
    send(5'b10101, 100, a);
    while (cyc < a + 30) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_e", int'(lcd_e), 0);
    chk("rst_mid_d", int'(lcd_d), 0);
    chk("rst_mid_busy", int'(busy), 0);
    sb.delete();
    send_command = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (120) @(negedge clk);
    chk("rst_idle_busy", int'(busy), 0);
    send(5'b00101, 0, a);
    wait_done(100, x);
    send_command = 1'b0;

    // maximum delay for the counter width
    send(5'b01111, 4095, a);
    wait_done(4200, x);
    send_command = 1'b0;

    repeat (4) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
